uart_fifo_ctrl: RTL and testbench

Bus-side host for the UART core. It buffers CPU writes in a TX FIFO and meters bytes into the core's tx_data/tx_en/tx_busy handshake. It captures each completed receive frame from the core's rx_ready/rx_data into an RX FIFO. It exposes both FIFOs as four word-aligned memory-mapped registers with status, overrun and interrupt logic for the Buceros peripheral bus.

---
 rtl/uart_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// Bus-side host for the UART core: TX/RX byte FIFOs behind four word registers,
// a small TX handshake FSM, RX frame capture with overrun, and a level interrupt.
module uart_fifo_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_en_o,
  input  logic        uart_tx_busy_i,
  input  logic        uart_rx_ready_i,
  input  logic [7:0]  uart_rx_data_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {RegTxData, RegRxData, RegStatus, RegCtrl} reg_e;
  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} tx_state_e;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CNT_W-1:0] tx_count_q, rx_count_q;
  tx_state_e        tx_state_q;
  logic [7:0]       tx_data_q;
  logic             tx_en_q;
  logic             rx_ready_q;
  logic             overrun_q;
  logic [1:0]       ctrl_q;
  logic [31:0]      rdata_q, rdata_d;

  reg_e reg_sel;
  logic tx_full, tx_empty, rx_full, rx_nonempty;
  logic wr_tx, rd_rx, wr_status, wr_ctrl;
  logic tx_pop, tx_push, rx_pop, rx_push_req, rx_push, rx_drop;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

  assign reg_sel     = reg_e'(addr_i[3:2]);
  assign tx_full     = (tx_count_q == DepthCnt);
  assign tx_empty    = (tx_count_q == '0);
  assign rx_full     = (rx_count_q == DepthCnt);
  assign rx_nonempty = (rx_count_q != '0);

  assign wr_tx     = we_i && (reg_sel == RegTxData);
  assign rd_rx     = re_i && (reg_sel == RegRxData);
  assign wr_status = we_i && (reg_sel == RegStatus);
  assign wr_ctrl   = we_i && (reg_sel == RegCtrl);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign tx_pop      = (tx_state_q == StIdle) && !tx_empty && !uart_tx_busy_i;
  assign tx_push     = wr_tx && (!tx_full || tx_pop);
  assign rx_pop      = rd_rx && rx_nonempty;
  assign rx_push_req = uart_rx_ready_i && !rx_ready_q;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_drop     = rx_push_req && !rx_push;

  assign status = {11'b0, tx_count_q, 3'b0, rx_count_q, 3'b0,
                   overrun_q, rx_nonempty, rx_full, tx_empty, tx_full};

  always_comb begin
    rdata_d = '0;
    unique case (reg_sel)
      RegTxData: rdata_d = '0;
      RegRxData: rdata_d = rx_nonempty ? {1'b1, 23'b0, rx_mem[rx_rd_ptr_q]} : '0;
      RegStatus: rdata_d = status;
      RegCtrl:   rdata_d = {30'b0, ctrl_q};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata_i[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_W'(1);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_W'(1);
      tx_count_q <= tx_count_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_count_q <= rx_count_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      unique case (tx_state_q)
        StIdle: begin
          if (tx_pop) begin
            tx_data_q  <= tx_mem[tx_rd_ptr_q];
            tx_en_q    <= 1'b1;
            tx_state_q <= StIssue;
          end
        end
        StIssue:    tx_state_q <= StWaitBusy;
        StWaitBusy: if (uart_tx_busy_i) tx_state_q <= StWaitDone;
        StWaitDone: if (!uart_tx_busy_i) tx_state_q <= StIdle;
        default:    tx_state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
      ctrl_q     <= '0;
      rdata_q    <= '0;
    end else begin
      rx_ready_q <= uart_rx_ready_i;
      // A new drop wins over a simultaneous software clear.
      if (rx_drop) begin
        overrun_q <= 1'b1;
      end else if (wr_status && wdata_i[4]) begin
        overrun_q <= 1'b0;
      end
      if (wr_ctrl) ctrl_q <= wdata_i[1:0];
      if (re_i) rdata_q <= rdata_d;
    end
  end

  assign rdata_o        = rdata_q;
  assign uart_tx_data_o = tx_data_q;
  assign uart_tx_en_o   = tx_en_q;
  assign irq_o          = (ctrl_q[0] && rx_nonempty) ||
                          (ctrl_q[1] && tx_empty && (tx_state_q == StIdle));

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: directed steps plus randomized TX/RX traffic
// compared against a queue-based model of the register-visible behaviour.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        irq_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_en_o;
  logic        uart_tx_busy_i;
  logic        uart_rx_ready_i = 1'b0;
  logic [7:0]  uart_rx_data_i = '0;

  logic core_busy = 1'b0;
  logic hold_busy = 1'b0;
  assign uart_tx_busy_i = core_busy | hold_busy;

  uart_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .addr_i          (addr_i),
    .we_i            (we_i),
    .re_i            (re_i),
    .wdata_i         (wdata_i),
    .rdata_o         (rdata_o),
    .irq_o           (irq_o),
    .uart_tx_data_o  (uart_tx_data_o),
    .uart_tx_en_o    (uart_tx_en_o),
    .uart_tx_busy_i  (uart_tx_busy_i),
    .uart_rx_ready_i (uart_rx_ready_i),
    .uart_rx_data_i  (uart_rx_data_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endfunction

  // Reference model: bytes accepted but not yet seen on tx_en, RX contents, flags.
  logic [7:0] tx_exp[$];
  logic [7:0] rx_q[$];
  bit         ovr = 1'b0;
  int         sent = 0;

  function automatic logic [31:0] status_exp(int txc);
    int rxc;
    logic [31:0] s;
    rxc = rx_q.size();
    s = '0;
    if (txc == DEPTH) s = s + 32'd1;
    if (txc == 0)     s = s + 32'd2;
    if (rxc == DEPTH) s = s + 32'd4;
    if (rxc != 0)     s = s + 32'd8;
    if (ovr)          s = s + 32'd16;
    s = s + (32'(rxc) << 8) + (32'(txc) << 16);
    return s;
  endfunction

  // Core model: busy rises one cycle after tx_en and stays high busy_len cycles.
  int         cyc = 0;
  int         fall_cyc = -100;
  int         busy_left = 0;
  int         busy_len = 20;
  bit         pend = 1'b0;
  bit         prev_en = 1'b0;
  logic [7:0] tx_e;

  always @(negedge clk) begin
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        core_busy = 1'b0;
        fall_cyc  = cyc;
      end
    end
    if (pend) begin
      core_busy = 1'b1;
      busy_left = busy_len;
      pend      = 1'b0;
    end
    if (uart_tx_en_o) begin
      check("tx_en_single_cycle", 32'(prev_en), 32'd0);
      check("tx_gap_after_busy", 32'((cyc - fall_cyc) >= 2), 32'd1);
      if (tx_exp.size() == 0) begin
        check("tx_unexpected_byte", 32'(uart_tx_data_o), 32'h1FF);
      end else begin
        tx_e = tx_exp.pop_front();
        check("tx_data", 32'(uart_tx_data_o), 32'(tx_e));
      end
      sent++;
      pend = 1'b1;
    end
    prev_en = uart_tx_en_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; re_i = 1'b1;
    @(negedge clk);
    re_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(4'h0, 32'(b));
    if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
  endtask

  task automatic rx_frame(input logic [7:0] b, input int len);
    @(negedge clk);
    uart_rx_ready_i = 1'b1; uart_rx_data_i = b;
    repeat (len) @(negedge clk);
    uart_rx_ready_i = 1'b0; uart_rx_data_i = 8'($urandom);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else ovr = 1'b1;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] d, e;
    e = (rx_q.size() != 0) ? (32'h8000_0000 | 32'(rx_q.pop_front())) : 32'h0;
    bus_read(4'h4, d);
    check(tag, d, e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (tx_exp.size() == 0 && !core_busy && !pend) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("tx_drained", 32'(tx_exp.size()), 32'd0);
  endtask

  logic [31:0] d;
  int          s0, n, cnt_en, op;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_tx_en", 32'(uart_tx_en_o), 32'd0);
    check("reset_tx_data", 32'(uart_tx_data_o), 32'd0);
    rst = 1'b0;
    bus_read(4'h8, d);
    check("status_after_reset", d, 32'h0000_0002);

    // Two bytes through the core handshake
    busy_len = 20;
    s0 = sent;
    tx_write(8'h55);
    tx_write(8'hA3);
    wait_drain();
    check("tx_two_sent", 32'(sent - s0), 32'd2);

    // Fill TX while the core is held busy; the ninth byte is dropped
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 1; i <= 9; i++) tx_write(8'(i));
    bus_read(4'h8, d);
    check("status_tx_full", d, status_exp(tx_exp.size()));
    check("status_tx_full_const", d, 32'h0008_0001);
    bus_read(4'h0, d);
    check("txdata_reads_zero", d, 32'h0);
    s0 = sent;
    @(negedge clk);
    hold_busy = 1'b0;
    wait_drain();
    check("tx_eight_sent", 32'(sent - s0), 32'd8);

    // Long ready pulse yields a single push
    rx_frame(8'h3C, 10);
    bus_read(4'h8, d);
    check("status_rx_one", d, status_exp(0));
    rx_read_check("rxdata_3c");
    rx_read_check("rxdata_empty");

    // Overrun on the ninth frame, then clear it
    for (int i = 0; i < 9; i++) rx_frame(8'(8'h10 + i), 2);
    bus_read(4'h8, d);
    check("status_overrun", d, status_exp(0));
    rx_read_check("rxdata_first_of_nine");
    bus_write(4'h8, 32'h10);
    ovr = 1'b0;
    bus_read(4'h8, d);
    check("status_overrun_cleared", d, status_exp(0));
    while (rx_q.size() != 0) rx_read_check("rxdata_drain");

    // Randomized RX traffic
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: rx_frame(8'($urandom), int'($urandom_range(1, 4)));
        2: rx_read_check("rxdata_rand");
        3: begin
          bus_read(4'h8, d);
          check("status_rand", d, status_exp(0));
        end
        default: begin
          d = $urandom;
          bus_write(4'h8, d);
          if (d[4]) ovr = 1'b0;
        end
      endcase
    end
    while (rx_q.size() != 0) rx_read_check("rxdata_rand_drain");
    bus_write(4'h8, 32'h10);
    ovr = 1'b0;
    bus_read(4'h8, d);
    check("status_after_rand_rx", d, status_exp(0));

    // Randomized TX traffic with varying busy lengths
    for (int r = 0; r < 4; r++) begin
      busy_len = int'($urandom_range(1, 6));
      n = int'($urandom_range(1, DEPTH));
      s0 = sent;
      for (int i = 0; i < n; i++) begin
        tx_write(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
      check("tx_rand_sent", 32'(sent - s0), 32'(n));
    end

    // Interrupt enables
    bus_write(4'hC, 32'hFFFF_FFFE);
    bus_read(4'hC, d);
    check("ctrl_readback", d, 32'h2);
    check("irq_tx_empty_idle", 32'(irq_o), 32'd1);
    bus_write(4'hC, 32'h1);
    @(negedge clk);
    check("irq_rx_empty", 32'(irq_o), 32'd0);
    uart_rx_ready_i = 1'b1; uart_rx_data_i = 8'h5A;
    check("irq_before_push", 32'(irq_o), 32'd0);
    @(negedge clk);
    check("irq_after_push", 32'(irq_o), 32'd1);
    uart_rx_ready_i = 1'b0;
    rx_q.push_back(8'h5A);
    rx_read_check("rxdata_irq");
    check("irq_after_pop", 32'(irq_o), 32'd0);

    // Reset while the FSM waits for the core to finish
    busy_len = 20;
    s0 = sent;
    tx_write(8'h11);
    tx_write(8'h22);
    tx_write(8'h33);
    for (int i = 0; i < 100 && sent == s0; i++) @(negedge clk);
    check("tx_before_reset", 32'(sent - s0), 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_exp.delete();
    rx_q.delete();
    ovr = 1'b0;
    check("midtx_reset_rdata", rdata_o, 32'h0);
    check("midtx_reset_irq", 32'(irq_o), 32'd0);
    cnt_en = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_tx_en_o) cnt_en++;
    end
    check("midtx_reset_no_tx_en", 32'(cnt_en), 32'd0);
    bus_read(4'h8, d);
    check("midtx_reset_status", d, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
